// File: rtl/class_hv_writer_if.sv
// Bundle of the sample-side handshake and the memory write stream of the
// class-hypervector writer. The block itself uses the slave view; the
// producer of samples and the consumer of writes use the master view.
interface class_hv_writer_if #(
   parameter int D           = 128,
   parameter int NUM_CLASSES = 16,
   parameter int CW          = 8,
   parameter int AW          = $clog2(NUM_CLASSES * D)
) ();

   localparam int CLW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

   logic           start;
   logic [CLW-1:0] class_id;
   logic           sample_valid;
   logic           sample_ready;
   logic [D-1:0]   sample_hv;
   logic           commit;
   logic           WE;
   logic [AW-1:0]  WriteAddr;
   logic           WriteData;
   logic           busy;
   logic           done;
   logic [CW-1:0]  sample_count;

   modport master (
      output start, class_id, sample_valid, sample_hv, commit,
      input  sample_ready, WE, WriteAddr, WriteData, busy, done, sample_count
   );

   modport slave (
      input  start, class_id, sample_valid, sample_hv, commit,
      output sample_ready, WE, WriteAddr, WriteData, busy, done, sample_count
   );

endinterface

// File: rtl/class_hv_writer.sv
// Class hypervector writer: majority-bundles accepted sample hypervectors
// into per-dimension counters, then streams the binarized class vector into
// memory one bit per address at class_id*D + k, k = 0..D-1.
module class_hv_writer #(
   parameter int D           = 128,
   parameter int NUM_CLASSES = 16,
   parameter int CW          = 8,
   parameter int AW          = $clog2(NUM_CLASSES * D)
) (
   input logic              clk,
   input logic              rst_n,
   class_hv_writer_if.slave bus
);

   localparam int CLW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
   localparam int KW  = $clog2(D);
   localparam int IW  = KW + 1;
   localparam logic [CW-1:0] MAX_SAMPLES = {CW{1'b1}};
   localparam logic [IW-1:0] LAST_IDX    = IW'(D);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Strict majority: 2*ones > total, evaluated one bit wider so it cannot wrap.
   // A tie or an empty class (total = 0) yields 0.
   function automatic logic majority_bit(input logic [CW-1:0] ones,
                                         input logic [CW-1:0] total);
      return ({ones, 1'b0} > {1'b0, total});
   endfunction

   state_t         state_r;
   state_t         state_nxt_s;
   logic [CW-1:0]  cnt_r [D];
   logic [CLW-1:0] class_r;
   logic [CW-1:0]  count_r;
   logic [CW-1:0]  count_nxt_s;
   logic [IW-1:0]  idx_r;
   logic [IW-1:0]  idx_nxt_s;
   logic [KW-1:0]  ki_s;
   logic           accept_s;
   logic [CW-1:0]  sel_cnt_s;
   logic           bit_s;
   logic [AW-1:0]  addr_s;

   logic           ready_r;
   logic           we_r;
   logic [AW-1:0]  waddr_r;
   logic           wdata_r;
   logic           busy_r;
   logic           done_r;

   // Next state, sample acceptance, write index and the bit/address to emit next.
   // On the commit cycle the sample accepted in that same cycle is folded into
   // dimension 0's count so the first write already reflects it.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      count_nxt_s = count_r;
      idx_nxt_s   = idx_r;
      ki_s        = {KW{1'b0}};
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_nxt_s = ACCUM;
               count_nxt_s = {CW{1'b0}};
               idx_nxt_s   = {IW{1'b0}};
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACCUM: begin
            accept_s = bus.sample_valid & ready_r;
            if (accept_s) begin
               count_nxt_s = count_r + CW'(1);
            end else begin
               count_nxt_s = count_r;
            end
            if (bus.commit) begin
               state_nxt_s = WRITE;
               idx_nxt_s   = IW'(1);
            end else begin
               state_nxt_s = ACCUM;
            end
         end
         WRITE: begin
            ki_s = idx_r[KW-1:0];
            if (idx_r == LAST_IDX) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = WRITE;
               idx_nxt_s   = idx_r + IW'(1);
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
      sel_cnt_s = cnt_r[ki_s] + CW'(accept_s & bus.sample_hv[ki_s]);
      bit_s     = majority_bit(sel_cnt_s, count_nxt_s);
      addr_s    = AW'(class_r) * AW'(D) + AW'(ki_s);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Class slot is captured only when a new class is started.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         class_r <= {CLW{1'b0}};
      end else if ((state_r == IDLE) && bus.start) begin
         class_r <= bus.class_id;
      end else begin
         class_r <= class_r;
      end
   end

   // Per-dimension vote counters: cleared on start, bumped on each accepted sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < D; i++) begin
            cnt_r[i] <= {CW{1'b0}};
         end
      end else if ((state_r == IDLE) && bus.start) begin
         for (int i = 0; i < D; i++) begin
            cnt_r[i] <= {CW{1'b0}};
         end
      end else if (accept_s) begin
         for (int i = 0; i < D; i++) begin
            cnt_r[i] <= cnt_r[i] + CW'(bus.sample_hv[i]);
         end
      end else begin
         for (int i = 0; i < D; i++) begin
            cnt_r[i] <= cnt_r[i];
         end
      end
   end

   // Registered outputs, sample count and write index, all derived from next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_r    <= 1'b0;
         waddr_r <= {AW{1'b0}};
         wdata_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         ready_r <= 1'b0;
         count_r <= {CW{1'b0}};
         idx_r   <= {IW{1'b0}};
      end else begin
         we_r <= (state_nxt_s == WRITE);
         if (state_nxt_s == WRITE) begin
            waddr_r <= addr_s;
            wdata_r <= bit_s;
         end else begin
            waddr_r <= waddr_r;
            wdata_r <= 1'b0;
         end
         busy_r  <= (state_nxt_s == ACCUM) || (state_nxt_s == WRITE);
         done_r  <= (state_nxt_s == DONE);
         ready_r <= (state_nxt_s == ACCUM) && (count_nxt_s < MAX_SAMPLES);
         count_r <= count_nxt_s;
         idx_r   <= idx_nxt_s;
      end
   end

   assign bus.sample_ready = ready_r;
   assign bus.WE           = we_r;
   assign bus.WriteAddr    = waddr_r;
   assign bus.WriteData    = wdata_r;
   assign bus.busy         = busy_r;
   assign bus.done         = done_r;
   assign bus.sample_count = count_r;

endmodule

// File: tb/tb_class_hv_writer.sv
// Bench for class_hv_writer with a small configuration (D=8, CW=2) so the
// majority, tie, saturation and full write-out cases stay short.
module tb_class_hv_writer;

   localparam int D  = 8;
   localparam int NC = 16;
   localparam int CW = 2;
   localparam int AW = $clog2(NC * D);

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          data;
   } wr_t;

   typedef struct {
      logic [3:0]    cid;
      int            n;
      logic [23:0]   hvs;        // sample j in bits [8*j +: 8]
      bit            simul;      // last sample shares its cycle with commit
      logic [CW-1:0] exp_count;
      logic [D-1:0]  exp_bits;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   wr_t  exp_q[$];
   vec_t vecs[7];

   class_hv_writer_if #(.D(D), .NUM_CLASSES(NC), .CW(CW), .AW(AW)) bus ();

   class_hv_writer #(.D(D), .NUM_CLASSES(NC), .CW(CW), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: run did not complete, errors so far %0d", errors);
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_class(input logic [3:0] cid, input logic [D-1:0] bits);
      wr_t e;
      for (int k = 0; k < D; k++) begin
         e.addr = AW'(int'(cid) * D + k);
         e.data = bits[k];
         exp_q.push_back(e);
      end
   endtask

   task automatic start_class(input logic [3:0] cid);
      bus.start    = 1'b1;
      bus.class_id = cid;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("start_busy",  32'(bus.busy), 32'd1);
      check("start_ready", 32'(bus.sample_ready), 32'd1);
      check("start_count", 32'(bus.sample_count), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic send_sample(input logic [D-1:0] hv, input bit with_commit);
      int n;
      n = 0;
      bus.sample_valid = 1'b1;
      bus.sample_hv    = hv;
      bus.commit       = with_commit;
      @(negedge clk);
      while (!bus.sample_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("sample_ready", 32'(bus.sample_ready), 32'd1);
      @(posedge clk); #1;
      bus.sample_valid = 1'b0;
      bus.commit       = 1'b0;
   endtask

   // Pops one expected write per WE cycle, then checks the done pulse and idle.
   task automatic drain(input logic [CW-1:0] exp_count, input bit poke);
      wr_t e;
      int  k;
      k = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         check("we_high", 32'(bus.WE), 32'd1);
         if (!bus.WE) begin
            exp_q.delete();
         end else begin
            e = exp_q.pop_front();
            check("write_addr",  32'(bus.WriteAddr), 32'(e.addr));
            check("write_data",  32'(bus.WriteData), 32'(e.data));
            check("busy_write",  32'(bus.busy), 32'd1);
            check("ready_write", 32'(bus.sample_ready), 32'd0);
            check("done_write",  32'(bus.done), 32'd0);
            if (k == 0) check("count_write", 32'(bus.sample_count), 32'(exp_count));
            bus.start = (poke && (k == 2)) ? 1'b1 : 1'b0;
            k++;
         end
      end
      bus.start = 1'b0;
      @(negedge clk);
      check("we_low_done", 32'(bus.WE), 32'd0);
      check("done_pulse",  32'(bus.done), 32'd1);
      check("busy_done",   32'(bus.busy), 32'd0);
      @(negedge clk);
      check("done_single", 32'(bus.done), 32'd0);
      check("busy_idle",   32'(bus.busy), 32'd0);
      check("ready_idle",  32'(bus.sample_ready), 32'd0);
      check("we_idle",     32'(bus.WE), 32'd0);
      check("count_hold",  32'(bus.sample_count), 32'(exp_count));
      @(posedge clk); #1;
   endtask

   task automatic run_vector(input vec_t v);
      push_class(v.cid, v.exp_bits);
      start_class(v.cid);
      for (int j = 0; j < v.n; j++) begin
         send_sample(v.hvs[8*j +: 8], v.simul && (j == v.n - 1));
      end
      if (!v.simul) begin
         bus.commit = 1'b1;
         @(posedge clk); #1;
         bus.commit = 1'b0;
      end
      drain(v.exp_count, v.simul);
   endtask

   initial begin
      wr_t e;
      checks           = 0;
      errors           = 0;
      rst_n            = 1'b1;
      bus.start        = 1'b0;
      bus.class_id     = 4'd0;
      bus.sample_valid = 1'b0;
      bus.sample_hv    = 8'h00;
      bus.commit       = 1'b0;

      // Majority, tie, empty, top slot, simultaneous sample+commit, 3-way vote.
      vecs[0] = '{cid: 4'd3,  n: 3, hvs: 24'hAACCF0, simul: 1'b0, exp_count: 2'd3, exp_bits: 8'hE8};
      vecs[1] = '{cid: 4'd5,  n: 2, hvs: 24'h000FFF, simul: 1'b0, exp_count: 2'd2, exp_bits: 8'h0F};
      vecs[2] = '{cid: 4'd0,  n: 0, hvs: 24'h000000, simul: 1'b0, exp_count: 2'd0, exp_bits: 8'h00};
      vecs[3] = '{cid: 4'd15, n: 1, hvs: 24'h00005A, simul: 1'b0, exp_count: 2'd1, exp_bits: 8'h5A};
      vecs[4] = '{cid: 4'd7,  n: 2, hvs: 24'h00FF00, simul: 1'b1, exp_count: 2'd2, exp_bits: 8'h00};
      vecs[5] = '{cid: 4'd12, n: 3, hvs: 24'h078381, simul: 1'b0, exp_count: 2'd3, exp_bits: 8'h83};
      vecs[6] = '{cid: 4'd2,  n: 1, hvs: 24'h00003C, simul: 1'b0, exp_count: 2'd1, exp_bits: 8'h3C};

      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_we",    32'(bus.WE), 32'd0);
      check("rst_addr",  32'(bus.WriteAddr), 32'd0);
      check("rst_data",  32'(bus.WriteData), 32'd0);
      check("rst_ready", 32'(bus.sample_ready), 32'd0);
      check("rst_busy",  32'(bus.busy), 32'd0);
      check("rst_done",  32'(bus.done), 32'd0);
      check("rst_count", 32'(bus.sample_count), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // commit while idle must not start anything
      bus.commit = 1'b1;
      @(posedge clk); #1;
      bus.commit = 1'b0;
      @(negedge clk);
      check("idle_commit_busy", 32'(bus.busy), 32'd0);
      check("idle_commit_we",   32'(bus.WE), 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         run_vector(vecs[i]);
      end

      // Saturation: valid held with all-ones for five edges, only three accepted.
      push_class(4'd9, 8'hFF);
      start_class(4'd9);
      bus.sample_valid = 1'b1;
      bus.sample_hv    = 8'hFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("sat_count2", 32'(bus.sample_count), 32'd2);
      check("sat_ready2", 32'(bus.sample_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("sat_count3", 32'(bus.sample_count), 32'd3);
      check("sat_ready3", 32'(bus.sample_ready), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("sat_count_hold", 32'(bus.sample_count), 32'd3);
      bus.sample_valid = 1'b0;
      bus.commit       = 1'b1;
      @(posedge clk); #1;
      bus.commit = 1'b0;
      drain(2'd3, 1'b0);

      // Reset in the middle of a write-out (k = 5 on the bus).
      push_class(4'd4, 8'hFF);
      start_class(4'd4);
      send_sample(8'hFF, 1'b0);
      bus.commit = 1'b1;
      @(posedge clk); #1;
      bus.commit = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("pre_rst_we", 32'(bus.WE), 32'd1);
         e = exp_q.pop_front();
         check("pre_rst_addr", 32'(bus.WriteAddr), 32'(e.addr));
      end
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_we",    32'(bus.WE), 32'd0);
      check("mid_rst_busy",  32'(bus.busy), 32'd0);
      check("mid_rst_count", 32'(bus.sample_count), 32'd0);
      check("mid_rst_ready", 32'(bus.sample_ready), 32'd0);
      check("mid_rst_done",  32'(bus.done), 32'd0);
      check("mid_rst_addr",  32'(bus.WriteAddr), 32'd0);
      exp_q.delete();
      @(negedge clk);
      check("held_rst_we", 32'(bus.WE), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_vector(vecs[6]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
